progmem_loader: RTL and testbench

PROGMEM_LOADER -- requirements
Module: progmem_loader

---
 rtl/progmem_loader_pkg.sv | 34 +++
 rtl/progmem_loader_if.sv | 52 +++++
 rtl/progmem_loader_word_assembler.sv | 63 ++++++
 rtl/progmem_loader.sv | 163 ++++++++++++++++
 tb/tb_progmem_loader.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/progmem_loader_pkg.sv
// -----------------------------------------------------------------------------
// progmem_loader_pkg
// Shared constants and types for the program-memory loader and the CPU that
// consumes the loaded image.
//   WORD_W          program memory word width (bits)
//   ADDR_W          program memory address width (bits)
//   BYTE_W          width of one stream byte
//   BYTES_PER_WORD  stream bytes per program word, MSB first
//   IDX_W           width of the byte-in-word index counter
//   state_e         loader FSM state encodings
// -----------------------------------------------------------------------------
package progmem_loader_pkg;

  localparam int WORD_W         = 40;
  localparam int ADDR_W         = 8;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 5;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

  // The loader takes bytes while a load is in progress; DONE and ERROR are
  // terminal until re-armed, so the upstream source is back-pressured there.
  function automatic logic accepts_bytes(state_e s);
    return (s == ST_IDLE) || (s == ST_LOAD) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/progmem_loader_if.sv
// -----------------------------------------------------------------------------
// progmem_loader_if
// Bundles the byte stream, the program memory write port and the control /
// status flags of the loader.
//   i_byte_valid / i_byte / o_byte_ready   upstream byte handshake
//   i_start                                 re-arm pulse (from DONE/ERROR)
//   o_wr_en / o_wr_addr / o_wr_data         program memory write port
//   o_cpu_run / o_error                     load result flags
// Modports:
//   master  the host side (byte source, start pulse, memory/CPU observer)
//   slave   the loader side
// -----------------------------------------------------------------------------
interface progmem_loader_if #(
  parameter int WORD_W = progmem_loader_pkg::WORD_W,
  parameter int ADDR_W = progmem_loader_pkg::ADDR_W
);

  logic              i_byte_valid;
  logic [7:0]        i_byte;
  logic              o_byte_ready;
  logic              i_start;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [WORD_W-1:0] o_wr_data;
  logic              o_cpu_run;
  logic              o_error;

  modport master (
    output i_byte_valid,
    output i_byte,
    output i_start,
    input  o_byte_ready,
    input  o_wr_en,
    input  o_wr_addr,
    input  o_wr_data,
    input  o_cpu_run,
    input  o_error
  );

  modport slave (
    input  i_byte_valid,
    input  i_byte,
    input  i_start,
    output o_byte_ready,
    output o_wr_en,
    output o_wr_addr,
    output o_wr_data,
    output o_cpu_run,
    output o_error
  );

endinterface

// File: rtl/progmem_loader_word_assembler.sv
// -----------------------------------------------------------------------------
// word_assembler
// Shifts accepted stream bytes into a program word (first byte ends up in the
// MSBs) and counts the byte position within the word.
//   clk_i        clock, rising edge
//   rst_ni       synchronous active-low reset
//   clear_i      drop any partial word and restart at byte 0
//   shift_i      a byte is accepted this cycle
//   byte_i       the byte being accepted
//   word_o       the word including byte_i (meaningful when word_done_o)
//   word_done_o  byte_i is the last byte of the current word
// -----------------------------------------------------------------------------
module word_assembler
  import progmem_loader_pkg::*;
#(
  parameter int WORD_W = progmem_loader_pkg::WORD_W,
  parameter int BYTES  = BYTES_PER_WORD
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              shift_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_done_o
);

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0] word_shifted;
  logic              last_byte;

  assign word_shifted = {word_q[WORD_W-BYTE_W-1:0], byte_i};
  assign last_byte    = (idx_q == IDX_W'(BYTES - 1));

  // The completed word is presented combinationally together with its final
  // byte so the loader can register it in the same cycle the byte is taken.
  assign word_o      = word_shifted;
  assign word_done_o = shift_i & last_byte;

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (clear_i) begin
      word_d = '0;
      idx_d  = '0;
    end else if (shift_i) begin
      word_d = word_shifted;
      idx_d  = last_byte ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/progmem_loader.sv
// -----------------------------------------------------------------------------
// progmem_loader
// Receives a program image as a byte stream (COUNT, COUNT+1 words of five
// bytes MSB first, CHK), writes each word into program memory at consecutive
// addresses from 0, and releases the CPU only when the XOR checksum of the
// word bytes matches CHK.
//   i_clk    clock, rising edge
//   i_rst_n  synchronous active-low reset
//   bus      progmem_loader_if.slave: byte handshake, i_start, memory write
//            port, o_cpu_run / o_error flags
// -----------------------------------------------------------------------------
module progmem_loader
  import progmem_loader_pkg::*;
#(
  parameter int WORD_W = progmem_loader_pkg::WORD_W,
  parameter int ADDR_W = progmem_loader_pkg::ADDR_W
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  progmem_loader_if.slave bus
);

  state_e            state_q, state_d;

  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BYTE_W-1:0] chk_q;
  logic              wr_en_q;
  logic [WORD_W-1:0] wr_data_q;

  logic              byte_ready;
  logic              cpu_run;
  logic              error_flag;
  logic              accept;
  logic              asm_clear;
  logic              asm_shift;
  logic              asm_done;
  logic [WORD_W-1:0] asm_word;
  logic              last_word;

  assign accept    = bus.i_byte_valid & byte_ready;
  assign asm_clear = (state_q == ST_IDLE);
  assign asm_shift = accept & (state_q == ST_LOAD);

  // addr_q already holds the index of the word being assembled: the previous
  // word's increment lands at least four cycles before this word completes.
  assign last_word = asm_done & (addr_q == count_q);

  word_assembler #(
    .WORD_W (WORD_W),
    .BYTES  (BYTES_PER_WORD)
  ) u_word_asm (
    .clk_i       (i_clk),
    .rst_ni      (i_rst_n),
    .clear_i     (asm_clear),
    .shift_i     (asm_shift),
    .byte_i      (bus.i_byte),
    .word_o      (asm_word),
    .word_done_o (asm_done)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (last_word) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (accept) state_d = (bus.i_byte == chk_q) ? ST_DONE : ST_ERROR;
      end
      ST_DONE, ST_ERROR: begin
        if (bus.i_start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (purely from the registered state, so a checksum verdict
  // shows up the cycle after the CHK byte is taken)
  // ---------------------------------------------------------------------------
  always_comb begin
    byte_ready = accepts_bytes(state_q);
    cpu_run    = 1'b0;
    error_flag = 1'b0;
    case (state_q)
      ST_DONE:  cpu_run    = 1'b1;
      ST_ERROR: error_flag = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: COUNT latch, running checksum, write strobe / address / data
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      count_q   <= '0;
      addr_q    <= '0;
      chk_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      // Strobe follows word completion by one cycle; data is held until the
      // next completed word, which is at least five accepts away.
      wr_en_q <= asm_done;
      if (asm_done) begin
        wr_data_q <= asm_word;
      end

      // Address advances after the strobe cycle so it is stable during it.
      if (wr_en_q) begin
        addr_q <= addr_q + ADDR_W'(1);
      end

      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            count_q <= ADDR_W'(bus.i_byte);
            chk_q   <= '0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            chk_q <= chk_q ^ bus.i_byte;
          end
        end
        ST_DONE, ST_ERROR: begin
          if (bus.i_start) begin
            addr_q <= '0;
            chk_q  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_byte_ready = byte_ready;
  assign bus.o_cpu_run    = cpu_run;
  assign bus.o_error      = error_flag;
  assign bus.o_wr_en      = wr_en_q;
  assign bus.o_wr_addr    = addr_q;
  assign bus.o_wr_data    = wr_data_q;

endmodule

// File: tb/tb_progmem_loader.sv
// -----------------------------------------------------------------------------
// tb_progmem_loader
// Drives byte streams into progmem_loader. Expected memory writes are queued
// when a stream is issued; a negedge monitor pops and compares every write
// strobe. Status flags are compared directly after each stream.
// -----------------------------------------------------------------------------
module tb_progmem_loader;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  progmem_loader_if bus ();

  progmem_loader dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [39:0] data;
    int          gap;   // required cycles since the previous strobe, 0 = any
  } exp_t;

  exp_t        exp_q[$];
  logic [39:0] words[256];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          last_wr_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Write-port monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (bus.o_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_strobe actual addr=%0h data=%0h required=no strobe",
                 bus.o_wr_addr, bus.o_wr_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(bus.o_wr_addr), 64'(e.addr));
        check("wr_data", 64'(bus.o_wr_data), 64'(e.data));
        if (e.gap != 0) check("wr_spacing", 64'(cyc - last_wr_cyc), 64'(e.gap));
      end
      last_wr_cyc = cyc;
    end
  end

  // Offer one byte; returns at the negedge after it has been accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    if (gap > 0) begin
      bus.i_byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    bus.i_byte_valid = 1'b1;
    bus.i_byte       = b;
    n = 0;
    while (bus.o_byte_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      total++;
      bad++;
      $display("FAIL ready_timeout actual=ready low for %0d cycles required=ready high", n);
      bus.i_byte_valid = 1'b0;
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic idle_cycles(input int n);
    bus.i_byte_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.i_byte_valid = 1'b0;
    bus.i_start      = 1'b1;
    @(negedge clk);
    bus.i_start      = 1'b0;
  endtask

  // Issue a stream built from words[0..nwords-1]. chk_override >= 0 replaces
  // the correct CHK byte; start_at pulses i_start before that byte index;
  // stop_at abandons the stream before that byte index (no CHK sent).
  task automatic load(input int nwords, input int maxgap, input int chk_override,
                      input int spacing, input int start_at, input int stop_at);
    logic [7:0] chk;
    logic [7:0] b;
    exp_t       e;
    int         nb;
    chk = 8'h00;
    nb  = 0;
    for (int w = 0; w < nwords; w++) begin
      if (stop_at < 0 || (w + 1) * 5 <= stop_at) begin
        e.addr = 8'(w);
        e.data = words[w];
        e.gap  = (w == 0) ? 0 : spacing;
        exp_q.push_back(e);
      end
    end
    send_byte(8'(nwords - 1), 0);
    for (int w = 0; w < nwords; w++) begin
      for (int k = 0; k < 5; k++) begin
        b   = words[w][39 - 8*k -: 8];
        chk = chk ^ b;
        if (nb == start_at) pulse_start();
        if (nb == stop_at) return;
        send_byte(b, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        nb++;
      end
    end
    send_byte((chk_override >= 0) ? 8'(chk_override) : chk, 0);
    idle_cycles(2);
  endtask

  task automatic check_flags(input string tag, input logic run, input logic err, input logic rdy);
    check({tag, "_cpu_run"}, 64'(bus.o_cpu_run), 64'(run));
    check({tag, "_error"}, 64'(bus.o_error), 64'(err));
    check({tag, "_ready"}, 64'(bus.o_byte_ready), 64'(rdy));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.i_byte_valid = 1'b0;
    bus.i_byte       = 8'h00;
    bus.i_start      = 1'b0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_en", 64'(bus.o_wr_en), 64'(0));
    check("rst_wr_addr", 64'(bus.o_wr_addr), 64'(0));
    check("rst_wr_data", 64'(bus.o_wr_data), 64'(0));
    check_flags("rst", 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single word, good checksum (01^02^03^04^05 = 01)
    words[0] = 40'h01_02_03_04_05;
    load(1, 0, 8'h01, 0, -1, -1);
    check_flags("one_word", 1'b1, 1'b0, 1'b0);
    check("one_word_drain", 64'(exp_q.size()), 64'(0));
    pulse_start();
    check_flags("rearm_done", 1'b0, 1'b0, 1'b1);
    check("rearm_done_addr", 64'(bus.o_wr_addr), 64'(0));

    // Two words back-to-back, strobes exactly five cycles apart
    words[0] = 40'h11_12_13_14_15;
    words[1] = 40'h16_17_18_19_1A;
    load(2, 0, -1, 5, -1, -1);
    check_flags("two_word", 1'b1, 1'b0, 1'b0);
    check("two_word_drain", 64'(exp_q.size()), 64'(0));
    pulse_start();

    // Bad checksum
    words[0] = 40'h01_02_03_04_05;
    load(1, 0, 8'hFF, 0, -1, -1);
    check_flags("bad_chk", 1'b0, 1'b1, 1'b0);
    pulse_start();
    check_flags("rearm_err", 1'b0, 1'b0, 1'b1);

    // i_start during LOAD is ignored (A1^A2^A3^A4^A5 = A1)
    words[0] = 40'hA1_A2_A3_A4_A5;
    load(1, 0, 8'hA1, 0, 2, -1);
    check_flags("start_in_load", 1'b1, 1'b0, 1'b0);
    pulse_start();

    // Reset after three bytes of word 2, then a fresh stream
    words[0] = 40'h21_22_23_24_25;
    words[1] = 40'h31_32_33_34_35;
    words[2] = 40'h41_42_43_44_45;
    load(3, 0, -1, 5, -1, 13);
    idle_cycles(1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("midrst_drain", 64'(exp_q.size()), 64'(0));
    check("midrst_wr_data", 64'(bus.o_wr_data), 64'(0));
    check("midrst_wr_addr", 64'(bus.o_wr_addr), 64'(0));
    check_flags("midrst", 1'b0, 1'b0, 1'b1);
    words[0] = 40'hC1_C2_C3_C4_C5;
    load(1, 0, -1, 0, -1, -1);
    check_flags("after_rst", 1'b1, 1'b0, 1'b0);
    pulse_start();

    // Full 256-word image with random valid gaps
    for (int w = 0; w < 256; w++) words[w] = {8'($urandom), 32'($urandom)};
    load(256, 2, -1, 0, -1, -1);
    check_flags("full", 1'b1, 1'b0, 1'b0);
    idle_cycles(3);
    check("full_drain", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
